// File: rtl/regfile_dump.sv
// regfile_dump: walks every integer register through a read port and streams
// {index, value[31:24..7:0]} frames followed by an XOR checksum byte.
`default_nettype none

module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rf_raddr,
  input  logic [XLEN-1:0]   i_rf_rdata,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready
);

  localparam logic [7:0] C_LAST_IDX  = 8'(NUM_REGS - 1);
  localparam logic [2:0] C_LAST_BYTE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state;
  logic [7:0]    r_reg_idx;
  logic [39:0]   r_shift;
  logic [2:0]    r_byte_cnt;
  logic [7:0]    r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_reg_idx  <= 8'd0;
      r_shift    <= 40'd0;
      r_byte_cnt <= 3'd0;
      r_csum     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_reg_idx <= 8'd0;
            r_csum    <= 8'd0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Each register is sampled exactly once, here; later writes are not seen.
          r_shift    <= {r_reg_idx, i_rf_rdata[31:0]};
          r_byte_cnt <= 3'd0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (i_tx_ready) begin
            r_csum     <= r_csum ^ r_shift[39:32];
            r_shift    <= {r_shift[31:0], 8'd0};
            r_byte_cnt <= r_byte_cnt + 3'd1;
            if (r_byte_cnt == C_LAST_BYTE) begin
              if (r_reg_idx == C_LAST_IDX) begin
                r_state <= S_CSUM;
              end else begin
                r_reg_idx <= r_reg_idx + 8'd1;
                r_state   <= S_LOAD;
              end
            end
          end
        end
        S_CSUM: begin
          if (i_tx_ready) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only registered state, so tx_ready never reaches them.
  always_comb begin
    o_busy     = (r_state != S_IDLE);
    o_done     = (r_state == S_DONE);
    o_tx_valid = (r_state == S_SEND) || (r_state == S_CSUM);
    o_tx_data  = 8'd0;
    o_rf_raddr = '0;
    if (r_state == S_SEND) begin
      o_tx_data = r_shift[39:32];
    end else if (r_state == S_CSUM) begin
      o_tx_data = r_csum;
    end
    if ((r_state == S_LOAD) || (r_state == S_SEND)) begin
      o_rf_raddr = ADDR_W'(r_reg_idx);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed table of dump scenarios plus hand sequences for
// reset, repeated start and mid-dump register updates.
`default_nettype none

module tb_regfile_dump;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_tx_ready = 1'b1;
  logic        o_busy, o_done, o_tx_valid;
  logic [4:0]  o_rf_raddr;
  logic [31:0] i_rf_rdata;
  logic [7:0]  o_tx_data;

  logic [31:0] rf [NR];
  logic [31:0] em [NR];
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];

  int n_vec = 0;
  int n_err = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  bit mon_pend = 1'b0;
  logic [7:0] mon_data = 8'd0;

  assign i_rf_rdata = rf[o_rf_raddr];

  regfile_dump #(.NUM_REGS(NR), .XLEN(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rf_raddr (o_rf_raddr),
    .i_rf_rdata (i_rf_rdata),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stream monitor: collects accepted bytes and checks valid/data hold under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pend = 1'b0;
    end else begin
      if (mon_pend) begin
        chk("hold_valid", 64'(o_tx_valid), 64'd1);
        chk("hold_data", 64'(o_tx_data), 64'(mon_data));
      end
      if (o_done) done_cnt++;
      if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
      if (o_tx_valid && !i_tx_ready) stall_cnt++;
      mon_pend = o_tx_valid && !i_tx_ready;
      mon_data = o_tx_data;
    end
  end

  task automatic build_exp();
    logic [7:0] cs;
    logic [7:0] b;
    logic [31:0] v;
    cs = 8'd0;
    exp_q.delete();
    for (int k = 0; k < NR; k++) begin
      v = em[k];
      for (int j = 0; j < 5; j++) begin
        case (j)
          0: b = 8'(k);
          1: b = v[31:24];
          2: b = v[23:16];
          3: b = v[15:8];
          default: b = v[7:0];
        endcase
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic cmp_stream(input string nm);
    int n;
    chk({nm, "_nbytes"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) chk($sformatf("%s_byte%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    n_vec++;
  endtask

  // One dump: start driven in the cycle after the previous done (or idle).
  task automatic run_dump(input bit stall, input int mod_at,
                          input logic [31:0] mod5, input logic [31:0] mod20);
    int c;
    bit seen;
    @(posedge clk); #1;
    chk("idle_busy", 64'(o_busy), 64'd0);
    got_q.delete();
    stall_cnt = 0;
    seen = 1'b0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    c = 1;
    while (c < 4000) begin
      if (c == 1) begin
        chk("c1_busy", 64'(o_busy), 64'd1);
        chk("c1_valid", 64'(o_tx_valid), 64'd0);
      end
      if (c == 2) begin
        chk("c2_valid", 64'(o_tx_valid), 64'd1);
        chk("c2_data", 64'(o_tx_data), 64'd0);
      end
      if (c == mod_at) begin
        rf[5]  = mod5;
        rf[20] = mod20;
      end
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      i_tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    i_tx_ready = 1'b1;
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    else chk("done_cycle", 64'(c), 64'(194 + stall_cnt));
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < NR; k++) rf[k] = (mode == 3) ? $urandom() : 32'd0;
    if (mode == 1 || mode == 4) rf[1] = 32'h1234_5678;
    if (mode == 2) rf[31] = 32'hDEAD_BEEF;
    em = rf;
  endtask

  typedef struct {
    string      name;
    int         mode;
    bit         stall;
    bit         has_csum;
    logic [7:0] csum;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int c;
    int d0;
    tbl[0] = '{"zeros",        0, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{"x1_pattern",   1, 1'b0, 1'b1, 8'h08};
    tbl[2] = '{"x31_deadbeef", 2, 1'b0, 1'b1, 8'h22};
    tbl[3] = '{"random_stall", 3, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{"x1_stall",     4, 1'b1, 1'b1, 8'h08};

    fill(0);
    #2;
    chk("rst_busy",  64'(o_busy),     64'd0);
    chk("rst_done",  64'(o_done),     64'd0);
    chk("rst_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_data",  64'(o_tx_data),  64'd0);
    chk("rst_raddr", 64'(o_rf_raddr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      fill(tbl[t].mode);
      build_exp();
      run_dump(tbl[t].stall, 0, 32'd0, 32'd0);
      cmp_stream(tbl[t].name);
      if (tbl[t].has_csum && got_q.size() == 5 * NR + 1)
        chk({tbl[t].name, "_csum"}, 64'(got_q[5 * NR]), 64'(tbl[t].csum));
    end

    // Register 5 rewritten after its LOAD (cycle 31), register 20 before its LOAD (cycle 121).
    fill(3);
    em[20] = 32'hCAFE_F00D;
    build_exp();
    run_dump(1'b0, 33, 32'h5555_AAAA, 32'hCAFE_F00D);
    cmp_stream("late_write");

    // Asynchronous reset in the middle of register 10's frame.
    fill(3);
    build_exp();
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    c = 0;
    while (!(o_rf_raddr == 5'd10 && o_tx_valid) && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_reg10", 64'(c < 500), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(o_busy),     64'd0);
    chk("arst_valid", 64'(o_tx_valid), 64'd0);
    chk("arst_raddr", 64'(o_rf_raddr), 64'd0);
    chk("arst_data",  64'(o_tx_data),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_done", 64'(done_cnt), 64'(d0));
    run_dump(1'b0, 0, 32'd0, 32'd0);
    cmp_stream("after_reset");

    // Start toggled throughout a dump: one dump, one done.
    fill(1);
    build_exp();
    @(posedge clk); #1;
    got_q.delete();
    d0 = done_cnt;
    i_start = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(posedge clk); #1;
      i_start = (k <= 190) ? 1'(k % 2) : 1'b0;
    end
    chk("multi_start_done", 64'(done_cnt - d0), 64'd1);
    cmp_stream("multi_start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine downstream of the RISC-V core's register file. On a start pulse it walks all integer registers through a dedicated read port and streams them out as a byte stream (index byte plus four value bytes per register), followed by an XOR checksum byte. It feeds a UART transmitter or debug FIFO, giving silicon the register visibility that simulation gets from hierarchical peeks.

## Interface
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1); ≤ 256
- XLEN, 32, register width; fixed at 32 (4 value bytes per frame)
- ADDR_W, 5, width of rf_raddr; 2^ADDR_W ≥ NUM_REGS
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  request a dump; sampled only in IDLE
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after checksum byte accepted
- rf_raddr  out  ADDR_W  register file read address
- rf_rdata  in  XLEN  combinational read data for rf_raddr, same cycle
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready at clk edge

## Operation
- States: IDLE, LOAD, SEND, CSUM, DONE.
- IDLE: busy=0, tx_valid=0, rf_raddr=0. start=1 → reg_idx=0, csum=0, go LOAD.
- LOAD (1 cycle): rf_raddr=reg_idx; capture 40-bit shift = {reg_idx[7:0], rf_rdata}; byte_cnt=0; go SEND.
- SEND: tx_valid=1, tx_data=shift[39:32]. On accept: csum ^= tx_data, shift <<= 8, byte_cnt++. Accept with byte_cnt==4: reg_idx==NUM_REGS-1 → CSUM, else reg_idx++ → LOAD.
- CSUM: tx_valid=1, tx_data=csum. On accept → DONE.
- DONE (1 cycle): done=1 → IDLE.
- Frame byte order: index, value[31:24], [23:16], [15:8], [7:0]. Total bytes = 5·NUM_REGS + 1 (161 default).
- Each register sampled once, in its LOAD cycle; no global snapshot. Writes to a register after its LOAD are not reflected.
- start ignored while busy; no queuing of a second request.
- rf_raddr held at reg_idx in LOAD/SEND; 0 in IDLE/CSUM/DONE.

## Timing
- Reset values: busy=0, done=0, tx_valid=0, tx_data=0, rf_raddr=0; state IDLE, counters and csum 0.
- Reset assertion mid-dump: outputs reach reset values without waiting for clk; partial frame abandoned; no done pulse.
- start sampled at edge E0 → LOAD in cycle 1; first tx_valid in cycle 2.
- Valid/ready: once tx_valid rises, tx_valid and tx_data hold stable until accepted; tx_valid never drops without acceptance except on reset.
- tx_ready high throughout: 6 cycles/register (LOAD + 5 SEND), LOAD/SEND spans cycles 1..192, CSUM cycle 193, done=1 in cycle 194, IDLE from cycle 195; busy high cycles 1..194.
- Each tx_ready-low cycle in SEND/CSUM adds exactly one cycle; LOAD never stalls.
- tx_ready has no combinational path to any output.
- start held high continuously: a new dump begins on the edge that samples it in IDLE (cycle 195 onward in the example above).

## Test plan
- All registers zero, tx_ready=1: start pulse → 161 bytes, frame k = {k,00,00,00,00}, checksum 0x00, done pulse in cycle 194 after start edge.
- x1=0x12345678, others 0: bytes 5..9 = 01 12 34 56 78; checksum 0x08.
- Random tx_ready backpressure (~50%) with random register contents: byte sequence identical to unstalled run; tx_data stable while tx_valid && !tx_ready; done delay = 194 + stall cycles.
- Reset asserted asynchronously mid-frame of register 10: tx_valid/busy drop before the next clk edge; after release a new start yields a full, correct 161-byte dump from register 0.
- start pulsed repeatedly while busy: exactly one dump, exactly one done pulse; a start in the cycle after done launches a second complete dump.
- Register 5 changed by bench after its LOAD cycle: stream shows old value; register 20 changed before its LOAD shows new value.
